// File: rtl/zipalu_pipelined.sv
// zipalu_pipelined: Zip CPU execute-stage ALU with a multi-cycle multiply path.
// Single-cycle ops register their result one clock after issue. Multiplies
// (MPY, MPYUHI, MPYSHI) take MPY_STAGES clocks and hold o_busy while in flight.
// Optional feature macro: ZIPALU_BITOPS_EN enables BREV (0xC) and POPC (0xD);
// without it those opcodes report o_illegal.
module zipalu_pipelined #(
    parameter int DW           = 32,
    parameter int IMPLEMENT_MPY = 1,
    parameter int MPY_STAGES    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ce,
    input  logic          i_valid,
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_c,
    output logic [3:0]    o_f,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_illegal
);

    localparam int             PW     = $clog2(DW + 1);
    localparam logic [DW-1:0]  DW_V   = DW'(DW);
    localparam bit             MPY_1  = (MPY_STAGES == 1);
    localparam bit             HAS_MPY = (IMPLEMENT_MPY != 0);

    logic [DW-1:0] r_c;
    logic [3:0]    r_f;
    logic          r_valid;
    logic          r_busy;
    logic          r_illegal;
    logic [2:0]    r_cnt;
    logic [3:0]    r_mop;
    logic [DW-1:0] r_ma;
    logic [DW-1:0] r_mb;

    logic          w_is_mpy;
    logic          w_is_bitop;
    logic          w_bitop_illegal;
    logic          w_illegal;

    // Opcode classification
    assign w_is_mpy   = (i_op == 4'h8) || (i_op == 4'hA) || (i_op == 4'hB);
    assign w_is_bitop = (i_op == 4'hC) || (i_op == 4'hD);
`ifdef ZIPALU_BITOPS_EN
    assign w_bitop_illegal = 1'b0;
`else
    assign w_bitop_illegal = w_is_bitop;
`endif
    assign w_illegal = (w_is_mpy && !HAS_MPY) || w_bitop_illegal;

    // Shift/arith helpers carry one extra bit so the carry falls out of the shift
    logic [DW:0]          w_sub;
    logic [DW:0]          w_add;
    logic [DW:0]          w_lsr;
    logic [DW:0]          w_lsl;
    logic signed [DW:0]   w_asr_in;
    logic signed [DW:0]   w_asr;
    logic [DW-1:0]        w_rot_amt;
    logic [2*DW-1:0]      w_rol2;
    logic [DW-1:0]        w_brev;
    logic [PW-1:0]        w_popc;

    assign w_sub     = {1'b0, i_a} - {1'b0, i_b};
    assign w_add     = {1'b0, i_a} + {1'b0, i_b};
    assign w_lsr     = {i_a, 1'b0} >> i_b;
    assign w_lsl     = {1'b0, i_a} << i_b;
    assign w_asr_in  = {i_a, 1'b0};
    assign w_asr     = w_asr_in >>> i_b;
    assign w_rot_amt = i_b % DW_V;
    assign w_rol2    = {i_a, i_a} << w_rot_amt;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_brev
            assign w_brev[gi] = i_b[DW-1-gi];
        end
    endgenerate

    // Population count of operand B
    always_comb begin
        w_popc = '0;
        for (int k = 0; k < DW; k++) begin
            w_popc = w_popc + PW'(i_b[k]);
        end
    end

    logic [DW-1:0] w_res;
    logic          w_cflag;
    logic          w_vflag;
    logic [3:0]    w_alu_f;

    // Single-cycle result and flag selection
    always_comb begin
        w_res   = i_b;
        w_cflag = 1'b0;
        w_vflag = 1'b0;
        case (i_op)
            4'h0: begin
                {w_cflag, w_res} = w_sub;
                w_vflag = (i_a[DW-1] != i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
            end
            4'h1: w_res = i_a & i_b;
            4'h2: begin
                {w_cflag, w_res} = w_add;
                w_vflag = (i_a[DW-1] == i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
            end
            4'h3: w_res = i_a | i_b;
            4'h4: w_res = i_a ^ i_b;
            4'h5: {w_res, w_cflag} = w_lsr;
            4'h6: begin
                {w_cflag, w_res} = w_lsl;
                w_vflag = (w_res[DW-1] != i_a[DW-1]);
            end
            4'h7: {w_res, w_cflag} = w_asr;
            4'h9: w_res = {i_a[DW-1:DW/2], i_b[DW/2-1:0]};
            4'hC: w_res = w_brev;
            4'hD: w_res = {{(DW-PW){1'b0}}, w_popc};
            4'hE: w_res = w_rol2[2*DW-1:DW];
            default: w_res = i_b;
        endcase
        w_alu_f = {w_vflag, w_res[DW-1], w_cflag, (w_res == '0)};
    end

    // Product of sign-extended or zero-extended operands, truncated to 2*DW
    function automatic logic [DW-1:0] mpy_calc(input logic [3:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [2*DW-1:0] ps;
        logic [2*DW-1:0] pu;
        logic [DW-1:0]   res;
        ps = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        case (op)
            4'h8:    res = ps[DW-1:0];
            4'hA:    res = pu[2*DW-1:DW];
            default: res = ps[2*DW-1:DW];
        endcase
        return res;
    endfunction

    // A single-stage multiplier works straight off the issue operands
    logic [3:0]    w_mop;
    logic [DW-1:0] w_ma;
    logic [DW-1:0] w_mb;
    logic [DW-1:0] w_mpy;
    logic [3:0]    w_mpy_f;

    assign w_mop   = MPY_1 ? i_op : r_mop;
    assign w_ma    = MPY_1 ? i_a  : r_ma;
    assign w_mb    = MPY_1 ? i_b  : r_mb;
    assign w_mpy   = mpy_calc(w_mop, w_ma, w_mb);
    assign w_mpy_f = {1'b0, w_mpy[DW-1], 1'b0, (w_mpy == '0)};

    // Issue, multiply sequencing and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c       <= '0;
            r_f       <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_mop     <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_busy) begin
                if (r_cnt == 3'd1) begin
                    r_c       <= w_mpy;
                    r_f       <= w_mpy_f;
                    r_valid   <= 1'b1;
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                end
            end else if (i_ce) begin
                if (w_illegal) begin
                    // o_c/o_f are left untouched for unimplemented ops
                    r_illegal <= 1'b1;
                    r_valid   <= i_valid;
                end else if (w_is_mpy) begin
                    if (MPY_1) begin
                        r_c       <= w_mpy;
                        r_f       <= w_mpy_f;
                        r_valid   <= i_valid;
                        r_illegal <= 1'b0;
                    end else if (i_valid) begin
                        // Bubbles never start the multiplier, so busy only
                        // ever covers real work
                        r_busy <= 1'b1;
                        r_cnt  <= 3'(MPY_STAGES - 1);
                        r_mop  <= i_op;
                        r_ma   <= i_a;
                        r_mb   <= i_b;
                    end
                end else begin
                    r_c       <= w_res;
                    r_f       <= w_alu_f;
                    r_valid   <= i_valid;
                    r_illegal <= 1'b0;
                end
            end
        end
    end

    assign o_c       = r_c;
    assign o_f       = r_f;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_zipalu_pipelined.sv
// tb_zipalu_pipelined: directed-vector bench for zipalu_pipelined.
// dut drives the default build (multiplier, 3 stages); dut_nm has no multiplier.
// Bit-op expectations follow ZIPALU_BITOPS_EN.
`timescale 1ns/1ps
module tb_zipalu_pipelined;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ce = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_op = 4'h0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;

    logic [31:0] o_c, o2_c;
    logic [3:0]  o_f, o2_f;
    logic        o_valid, o_busy, o_illegal;
    logic        o2_valid, o2_busy, o2_illegal;

    int total = 0;
    int bad = 0;

    zipalu_pipelined #(.DW(32), .IMPLEMENT_MPY(1), .MPY_STAGES(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_valid(i_valid),
        .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .o_c(o_c), .o_f(o_f), .o_valid(o_valid), .o_busy(o_busy),
        .o_illegal(o_illegal)
    );

    zipalu_pipelined #(.DW(32), .IMPLEMENT_MPY(0), .MPY_STAGES(3)) dut_nm (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_valid(i_valid),
        .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .o_c(o2_c), .o_f(o2_f), .o_valid(o2_valid), .o_busy(o2_busy),
        .o_illegal(o2_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Packed observation: {valid, busy, illegal, f[3:0], c[31:0]}
    logic [38:0] obs1, obs2;
    assign obs1 = {o_valid, o_busy, o_illegal, o_f, o_c};
    assign obs2 = {o2_valid, o2_busy, o2_illegal, o2_f, o2_c};

    // Present one op for one edge, then sample 1 ns after that edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        i_ce = 1'b1; i_valid = v; i_op = op; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_ce = 1'b0; i_valid = 1'b0;
        $display("op=%h a=%h b=%h v=%0d -> c=%h f=%b valid=%0d busy=%0d ill=%0d",
                 op, a, b, v, o_c, o_f, o_valid, o_busy, o_illegal);
    endtask

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ce = 1'b1; i_valid = 1'b1; i_op = 4'h2; i_a = 32'h1; i_b = 32'h1;
        tick(); tick();
        i_ce = 1'b0; i_valid = 1'b0;
        total++;
        if (obs1 !== 39'h0) begin bad++; $display("FAIL reset_dut got=%h want=%h", obs1, 39'h0); end
        total++;
        if (obs2 !== 39'h0) begin bad++; $display("FAIL reset_dut_nm got=%h want=%h", obs2, 39'h0); end
        i_rst = 1'b0;
        tick();
        total++;
        if (obs1 !== 39'h0) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs1, 39'h0); end
    endtask

    task automatic test_add_sub();
        issue(4'h2, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b1100, 32'h80000000})
            begin bad++; $display("FAIL add_ovf got=%h want=%h", obs1, {3'b100, 4'b1100, 32'h80000000}); end
        tick();
        total++;
        if (obs1 !== {3'b000, 4'b1100, 32'h80000000})
            begin bad++; $display("FAIL add_hold got=%h want=%h", obs1, {3'b000, 4'b1100, 32'h80000000}); end
        issue(4'h0, 32'h00000000, 32'h00000001, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0110, 32'hFFFFFFFF})
            begin bad++; $display("FAIL sub_borrow got=%h want=%h", obs1, {3'b100, 4'b0110, 32'hFFFFFFFF}); end
    endtask

    task automatic test_logic();
        issue(4'h1, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0001, 32'h0})
            begin bad++; $display("FAIL and_zero got=%h want=%h", obs1, {3'b100, 4'b0001, 32'h0}); end
        issue(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'h0FF00FF0})
            begin bad++; $display("FAIL xor got=%h want=%h", obs1, {3'b100, 4'b0000, 32'h0FF00FF0}); end
        issue(4'h9, 32'h12345678, 32'hABCDEF01, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'h1234EF01})
            begin bad++; $display("FAIL ldilo got=%h want=%h", obs1, {3'b100, 4'b0000, 32'h1234EF01}); end
    endtask

    task automatic test_shift();
        issue(4'h5, 32'h80000001, 32'd1, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0010, 32'h40000000})
            begin bad++; $display("FAIL lsr1 got=%h want=%h", obs1, {3'b100, 4'b0010, 32'h40000000}); end
        issue(4'h7, 32'h80000000, 32'd40, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0110, 32'hFFFFFFFF})
            begin bad++; $display("FAIL asr40 got=%h want=%h", obs1, {3'b100, 4'b0110, 32'hFFFFFFFF}); end
        issue(4'h6, 32'h40000001, 32'd1, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b1100, 32'h80000002})
            begin bad++; $display("FAIL lsl_v got=%h want=%h", obs1, {3'b100, 4'b1100, 32'h80000002}); end
        issue(4'h5, 32'h00000005, 32'd0, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'h00000005})
            begin bad++; $display("FAIL lsr0 got=%h want=%h", obs1, {3'b100, 4'b0000, 32'h00000005}); end
        issue(4'h5, 32'hFFFFFFFF, 32'd33, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0001, 32'h0})
            begin bad++; $display("FAIL lsr33 got=%h want=%h", obs1, {3'b100, 4'b0001, 32'h0}); end
        issue(4'h6, 32'h00000001, 32'd32, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0011, 32'h0})
            begin bad++; $display("FAIL lsl32 got=%h want=%h", obs1, {3'b100, 4'b0011, 32'h0}); end
        issue(4'hE, 32'h80000001, 32'd33, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'h00000003})
            begin bad++; $display("FAIL rol33 got=%h want=%h", obs1, {3'b100, 4'b0000, 32'h00000003}); end
    endtask

    task automatic test_mpy();
        issue(4'hB, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        total++;
        if ({o_valid, o_busy} !== 2'b01)
            begin bad++; $display("FAIL mpy_busy1 got=%b want=%b", {o_valid, o_busy}, 2'b01); end
        // Try to slip an ADD in while busy; it must be dropped
        i_ce = 1'b1; i_valid = 1'b1; i_op = 4'h2; i_a = 32'h1; i_b = 32'h1;
        tick();
        total++;
        if ({o_valid, o_busy} !== 2'b01)
            begin bad++; $display("FAIL mpy_busy2 got=%b want=%b", {o_valid, o_busy}, 2'b01); end
        tick();
        i_ce = 1'b0; i_valid = 1'b0;
        $display("mpyshi done -> c=%h f=%b valid=%0d busy=%0d", o_c, o_f, o_valid, o_busy);
        total++;
        if (obs1 !== {3'b100, 4'b0100, 32'hFFFFFFFF})
            begin bad++; $display("FAIL mpyshi got=%h want=%h", obs1, {3'b100, 4'b0100, 32'hFFFFFFFF}); end
        tick();
        total++;
        if (obs1 !== {3'b000, 4'b0100, 32'hFFFFFFFF})
            begin bad++; $display("FAIL mpy_drop got=%h want=%h", obs1, {3'b000, 4'b0100, 32'hFFFFFFFF}); end
        issue(4'h8, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        tick(); tick();
        total++;
        if (obs1 !== {3'b100, 4'b0100, 32'hFFFFFFFA})
            begin bad++; $display("FAIL mpy_lo got=%h want=%h", obs1, {3'b100, 4'b0100, 32'hFFFFFFFA}); end
        issue(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        tick(); tick();
        total++;
        if (obs1 !== {3'b100, 4'b0100, 32'hFFFFFFFE})
            begin bad++; $display("FAIL mpyuhi got=%h want=%h", obs1, {3'b100, 4'b0100, 32'hFFFFFFFE}); end
    endtask

    task automatic test_mpy_reset();
        int pulses;
        issue(4'h8, 32'd3, 32'd4, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++;
        if (obs1 !== 39'h0)
            begin bad++; $display("FAIL mpy_rst got=%h want=%h", obs1, 39'h0); end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (o_valid || o_busy) pulses++;
        end
        total++;
        if (pulses !== 0)
            begin bad++; $display("FAIL mpy_rst_quiet got=%0d want=%0d", pulses, 0); end
        issue(4'h2, 32'd2, 32'd3, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'd5})
            begin bad++; $display("FAIL add_after_rst got=%h want=%h", obs1, {3'b100, 4'b0000, 32'd5}); end
    endtask

    task automatic test_bitops();
`ifdef ZIPALU_BITOPS_EN
        issue(4'hC, 32'h0, 32'h00000001, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0100, 32'h80000000})
            begin bad++; $display("FAIL brev got=%h want=%h", obs1, {3'b100, 4'b0100, 32'h80000000}); end
        issue(4'hD, 32'h0, 32'hF0F0000F, 1'b1);
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'd12})
            begin bad++; $display("FAIL popc got=%h want=%h", obs1, {3'b100, 4'b0000, 32'd12}); end
`else
        issue(4'hC, 32'h0, 32'h00000001, 1'b1);
        total++;
        if (obs1 !== {3'b101, 4'b0000, 32'd5})
            begin bad++; $display("FAIL brev_illegal got=%h want=%h", obs1, {3'b101, 4'b0000, 32'd5}); end
        issue(4'hD, 32'h0, 32'hF0F0000F, 1'b1);
        total++;
        if (obs1 !== {3'b101, 4'b0000, 32'd5})
            begin bad++; $display("FAIL popc_illegal got=%h want=%h", obs1, {3'b101, 4'b0000, 32'd5}); end
`endif
    endtask

    task automatic test_no_mpy();
        issue(4'hF, 32'h0, 32'h00000055, 1'b1);
        total++;
        if (obs2 !== {3'b100, 4'b0000, 32'h55})
            begin bad++; $display("FAIL nm_mov got=%h want=%h", obs2, {3'b100, 4'b0000, 32'h55}); end
        issue(4'h8, 32'd3, 32'd4, 1'b1);
        total++;
        if (obs2 !== {3'b101, 4'b0000, 32'h55})
            begin bad++; $display("FAIL nm_mpy_illegal got=%h want=%h", obs2, {3'b101, 4'b0000, 32'h55}); end
        tick(); tick();
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'd12})
            begin bad++; $display("FAIL mpy_3x4 got=%h want=%h", obs1, {3'b100, 4'b0000, 32'd12}); end
        total++;
        if ({o2_valid, o2_busy} !== 2'b00)
            begin bad++; $display("FAIL nm_idle got=%b want=%b", {o2_valid, o2_busy}, 2'b00); end
        issue(4'h2, 32'd1, 32'd1, 1'b0);
        total++;
        if ({o_valid, o_busy, o2_valid, o2_busy} !== 4'b0000)
            begin bad++; $display("FAIL bubble_add got=%b want=%b", {o_valid, o_busy, o2_valid, o2_busy}, 4'b0000); end
        issue(4'h8, 32'd1, 32'd1, 1'b0);
        tick();
        total++;
        if ({o_valid, o_busy} !== 2'b00)
            begin bad++; $display("FAIL bubble_mpy got=%b want=%b", {o_valid, o_busy}, 2'b00); end
    endtask

    task automatic test_back_to_back();
        i_ce = 1'b1; i_valid = 1'b1; i_op = 4'h2; i_a = 32'd10; i_b = 32'd20;
        tick();
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'd30})
            begin bad++; $display("FAIL b2b_add got=%h want=%h", obs1, {3'b100, 4'b0000, 32'd30}); end
        i_op = 4'h3; i_a = 32'h0000F000; i_b = 32'h0000000F;
        tick();
        total++;
        if (obs1 !== {3'b100, 4'b0000, 32'h0000F00F})
            begin bad++; $display("FAIL b2b_or got=%h want=%h", obs1, {3'b100, 4'b0000, 32'h0000F00F}); end
        i_op = 4'h0; i_a = 32'h80000000; i_b = 32'h00000001;
        tick();
        i_ce = 1'b0; i_valid = 1'b0;
        total++;
        if (obs1 !== {3'b100, 4'b1000, 32'h7FFFFFFF})
            begin bad++; $display("FAIL b2b_sub_v got=%h want=%h", obs1, {3'b100, 4'b1000, 32'h7FFFFFFF}); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mpy();
        test_mpy_reset();
        test_bitops();
        test_no_mpy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zipalu_pipelined.md
Name: zipalu_pipelined

Overview:
- Parametrised successor ALU for the Zip CPU execute stage.
- Data width is generic.
- Multiply is multi-cycle and pipelined, with a busy/valid handshake.
- Adds bit-reverse, population-count and high-word multiply opcodes.
- Sits between operand read and writeback. Single-cycle ops complete in 1 clock; multiplies complete in MPY_STAGES clocks while o_busy stalls issue.

Parameters:
- DW, 32: operand/result width; even, 16..64.
- IMPLEMENT_MPY, 1: 0 = no multiplier (MPY ops illegal); 1 = multiplier present.
- MPY_STAGES, 3: multiply latency in clocks, 1..4; ignored when IMPLEMENT_MPY=0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_ce  in  1  issue strobe; accepted only when o_busy=0
- i_valid  in  1  issued op is real (not a bubble)
- i_op  in  4  opcode
- i_a  in  DW  operand A
- i_b  in  DW  operand B / shift amount
- o_c  out  DW  result
- o_f  out  4  flags {V,N,C,Z}
- o_valid  out  1  one-cycle pulse: o_c/o_f/o_illegal valid
- o_busy  out  1  multiply in flight; no issue accepted
- o_illegal  out  1  op not implemented; qualified by o_valid

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_valid=0, o_busy=0, o_illegal=0, o_c=0, o_f=0.
  - Pipeline counter cleared; any in-flight multiply is discarded and produces no o_valid.
  - Reset has priority over i_ce in the same cycle.
- Opcodes:
  - 0 SUB: {C,c} = {0,a} - {0,b}; C = borrow.
  - 1 AND.
  - 2 ADD: C = carry out.
  - 3 OR.
  - 4 XOR.
  - 5 LSR, 6 LSL, 7 ASR.
  - 8 MPY: low DW bits of signed product.
  - 9 LDILO: {a[DW-1:DW/2], b[DW/2-1:0]}.
  - A MPYUHI: high DW bits, unsigned.
  - B MPYSHI: high DW bits, signed.
  - C BREV: result[i] = b[DW-1-i].
  - D POPC: count of ones in b, zero-extended.
  - E ROL: a rotated left by b mod DW.
  - F MOV: b.
- Shifts (amount n = full unsigned i_b):
  - n=0: result a, C=0.
  - 1..DW: C = last bit shifted out.
  - n>DW: LSR/LSL give result 0, C=0. ASR gives all a[DW-1], C=a[DW-1].
- Flags:
  - Z = (result==0); N = result[DW-1].
  - V, ADD: sign(a)==sign(b) and sign(result)!=sign(a).
  - V, SUB: signs differ and sign(result)!=sign(a).
  - V, LSL: sign(result)!=sign(a).
  - V=0 for all other ops; C=0 for ops not listed as setting it.
- Single-cycle path:
  - i_ce&&!o_busy with a non-multiply op registers the result on that edge.
  - o_valid = i_valid on the next cycle (1-clock latency).
- Multiply path (IMPLEMENT_MPY=1, op 8/A/B):
  - On accept, o_busy rises the next cycle; operands and opcode are latched.
  - Stage counter loads MPY_STAGES-1 and decrements.
  - When the counter reaches 0: o_c/o_f update, o_valid pulses (if the latched i_valid=1), o_busy falls in the same cycle.
  - Total accept-to-o_valid = MPY_STAGES clocks. MPY_STAGES=1 behaves as single-cycle with o_busy never asserted.
  - Multiply flags: Z, N from result; C=0, V=0.
- i_ce while o_busy: ignored (no state change); the issuer must hold the op.
- Bubble (i_ce=1, i_valid=0): result/flags may update, o_valid stays 0, o_busy not asserted.
- Illegal ops (multiply with IMPLEMENT_MPY=0, or bit-op with feature off):
  - o_c, o_f unchanged.
  - o_illegal=1 together with o_valid=i_valid, 1-clock latency, no busy.
- o_c/o_f hold their last value between o_valid pulses.

Optional Feature:
- Macro: ZIPALU_BITOPS_EN.
- Defined: BREV (C) and POPC (D) implemented as above.
- Undefined: opcodes C and D take the illegal path (o_illegal=1 with o_valid, 1-clock latency, o_c/o_f unchanged). All other opcodes are unaffected.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 (DW=32) -> o_c=0x80000000, o_f={V=1,N=1,C=0,Z=0}, o_valid 1 clock after i_ce.
- SUB 0x00000000 - 0x00000001 -> o_c=0xFFFFFFFF, C=1, N=1, V=0. LSR 0x80000001 by 1 -> 0x40000000, C=1. ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1.
- MPYSHI 0xFFFFFFFE * 0x00000003 (MPY_STAGES=3):
  - o_busy high for 2 cycles; o_c=0xFFFFFFFF, o_valid exactly 3 clocks after accept.
  - An i_ce issued while busy is dropped.
- i_rst asserted 1 clock into a 3-stage MPY -> o_busy=0 and o_valid never pulses for that op. A following ADD completes normally.
- With ZIPALU_BITOPS_EN: BREV 0x00000001 -> 0x80000000; POPC 0xF0F0000F -> 12.
  - Without it: op C -> o_illegal=1, o_valid=1, o_c unchanged.
- IMPLEMENT_MPY=0: op 8 -> o_illegal=1 with o_valid after 1 clock, o_busy stays 0. Bubble op (i_valid=0) -> no o_valid.
